// File: rtl/recv_word_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module : recv_word_pkg
// Brief  : Shared UART receive definitions: frame FSM encoding, line levels.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
package recv_word_pkg;

    // Frame FSM state encoding
    typedef logic [2:0] frame_state_t;

    localparam frame_state_t ST_IDLE      = 3'd0;
    localparam frame_state_t ST_START     = 3'd1;
    localparam frame_state_t ST_DATA      = 3'd2;
    localparam frame_state_t ST_STOP      = 3'd3;
    localparam frame_state_t ST_WAIT_IDLE = 3'd4;

    // Serial line levels
    localparam logic UART_IDLE_LEVEL = 1'b1;
    localparam logic START_LEVEL     = 1'b0;

endpackage
`default_nettype wire

// File: rtl/recv_word_if.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module : recv_word_if
// Brief  : Serial line in, reassembled word and status pulses out.
//          master = line driver / word consumer, slave = recv_word.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
interface recv_word_if #(
    parameter int DATA_SIZE = 16
) ();

    logic                 rx_in;
    logic [DATA_SIZE-1:0] data_out;
    logic                 valid_out;
    logic                 busy_out;
    logic                 frame_err_out;
    logic                 timeout_out;

    modport master (
        output rx_in,
        input  data_out, valid_out, busy_out, frame_err_out, timeout_out
    );

    modport slave (
        input  rx_in,
        output data_out, valid_out, busy_out, frame_err_out, timeout_out
    );

endinterface
`default_nettype wire

// File: rtl/recv_word_uart_rx_frame.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module : uart_rx_frame
// Brief  : Single UART frame receiver: 2-FF synchroniser, bit timer and
//          frame FSM (start, FRAME_SIZE data bits LSB first, one stop bit).
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
module uart_rx_frame
    import recv_word_pkg::*;
#(
    parameter int CLK_BAUD_RATIO = 25,
    parameter int FRAME_SIZE     = 8
) (
    input  wire logic                  clk,
    input  wire logic                  rst_n,
    input  wire logic                  rx,
    output logic [FRAME_SIZE-1:0]      frame_out,
    output logic                       frame_done,
    output logic                       frame_err,
    output logic                       line_idle,
    output logic                       start_seen,
    output logic                       start_ok
);

    localparam int TW = $clog2(CLK_BAUD_RATIO);
    localparam int IW = (FRAME_SIZE > 1) ? $clog2(FRAME_SIZE) : 1;

    localparam logic [TW-1:0] c_half = TW'(CLK_BAUD_RATIO / 2);
    localparam logic [TW-1:0] c_full = TW'(CLK_BAUD_RATIO - 1);
    localparam logic [TW-1:0] c_one  = TW'(1);
    localparam logic [IW-1:0] c_last = IW'(FRAME_SIZE - 1);
    localparam logic [IW-1:0] c_inc  = IW'(1);

    logic                  r_sync1;
    logic                  r_sync2;
    logic                  r_prev;
    frame_state_t          r_state;
    logic [TW-1:0]         r_timer;
    logic [IW-1:0]         r_idx;
    logic [FRAME_SIZE-1:0] r_shift;

    logic w_fall;
    logic w_expired;

    assign w_fall    = (r_prev == UART_IDLE_LEVEL) && (r_sync2 == START_LEVEL);
    assign w_expired = (r_timer == '0);

    // Synchronise the asynchronous line and keep one extra stage for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= UART_IDLE_LEVEL;
            r_sync2 <= UART_IDLE_LEVEL;
            r_prev  <= UART_IDLE_LEVEL;
        end else begin
            r_sync1 <= rx;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
        end
    end

    // Frame FSM: half-bit to the start-bit centre, then one full bit per sample
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_timer <= '0;
            r_idx   <= '0;
            r_shift <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_fall) begin
                        r_timer <= c_half;
                        r_state <= ST_START;
                    end
                end
                ST_START: begin
                    if (w_expired) begin
                        if (r_sync2 == START_LEVEL) begin
                            r_idx   <= '0;
                            r_timer <= c_full;
                            r_state <= ST_DATA;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end else begin
                        r_timer <= r_timer - c_one;
                    end
                end
                ST_DATA: begin
                    if (w_expired) begin
                        r_shift <= (r_shift >> 1) | (FRAME_SIZE'(r_sync2) << (FRAME_SIZE - 1));
                        r_timer <= c_full;
                        if (r_idx == c_last) begin
                            r_state <= ST_STOP;
                        end else begin
                            r_idx <= r_idx + c_inc;
                        end
                    end else begin
                        r_timer <= r_timer - c_one;
                    end
                end
                ST_STOP: begin
                    if (w_expired) begin
                        r_state <= (r_sync2 == UART_IDLE_LEVEL) ? ST_IDLE : ST_WAIT_IDLE;
                    end else begin
                        r_timer <= r_timer - c_one;
                    end
                end
                ST_WAIT_IDLE: begin
                    if (r_sync2 == UART_IDLE_LEVEL) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Event strobes are decoded straight from the sampling cycle
    assign frame_out  = r_shift;
    assign frame_done = (r_state == ST_STOP)  && w_expired && (r_sync2 == UART_IDLE_LEVEL);
    assign frame_err  = (r_state == ST_STOP)  && w_expired && (r_sync2 == START_LEVEL);
    assign start_ok   = (r_state == ST_START) && w_expired && (r_sync2 == START_LEVEL);
    assign start_seen = (r_state == ST_IDLE)  && w_fall;
    assign line_idle  = (r_state == ST_IDLE);

endmodule
`default_nettype wire

// File: rtl/recv_word.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module : recv_word
// Brief  : Receives FRAMES UART frames and reassembles them into one word,
//          first frame in the lowest bits; flags framing errors and gap
//          timeouts between frames of a word.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
module recv_word
    import recv_word_pkg::*;
#(
    parameter int CLK_BAUD_RATIO = 25,
    parameter int FRAME_SIZE     = 8,
    parameter int FRAMES         = 2,
    parameter int GAP_TIMEOUT    = 16
) (
    input  wire logic clk_in,
    input  wire logic rst_n_in,
    recv_word_if.slave bus
);

    localparam int DATA_SIZE = FRAME_SIZE * FRAMES;
    localparam int KW        = $clog2(FRAMES + 1);
    localparam int GAP_LIMIT = GAP_TIMEOUT * CLK_BAUD_RATIO;
    localparam int GW        = $clog2(GAP_LIMIT + 1);

    localparam logic [KW-1:0] c_k_last   = KW'(FRAMES - 1);
    localparam logic [KW-1:0] c_k_inc    = KW'(1);
    localparam logic [GW-1:0] c_gap_last = GW'(GAP_LIMIT - 1);
    localparam logic [GW-1:0] c_gap_inc  = GW'(1);

    logic [FRAME_SIZE-1:0] w_frame;
    logic                  w_frame_done;
    logic                  w_frame_err;
    logic                  w_line_idle;
    logic                  w_start_seen;
    logic                  w_start_ok;
    logic [DATA_SIZE-1:0]  w_word_next;
    logic                  w_gap_run;
    logic                  w_gap_hit;

    logic [KW-1:0]         r_k;
    logic [GW-1:0]         r_gap;
    logic [DATA_SIZE-1:0]  r_word;
    logic [DATA_SIZE-1:0]  r_data;
    logic                  r_valid;
    logic                  r_busy;
    logic                  r_ferr;
    logic                  r_tmo;

    uart_rx_frame #(
        .CLK_BAUD_RATIO (CLK_BAUD_RATIO),
        .FRAME_SIZE     (FRAME_SIZE)
    ) u_frame (
        .clk        (clk_in),
        .rst_n      (rst_n_in),
        .rx         (bus.rx_in),
        .frame_out  (w_frame),
        .frame_done (w_frame_done),
        .frame_err  (w_frame_err),
        .line_idle  (w_line_idle),
        .start_seen (w_start_seen),
        .start_ok   (w_start_ok)
    );

    // Drop the just-received frame into its slot of the partial word
    always_comb begin
        w_word_next = r_word;
        for (int i = 0; i < FRAMES; i++) begin
            if (r_k == KW'(i)) begin
                w_word_next[i*FRAME_SIZE +: FRAME_SIZE] = w_frame;
            end
        end
    end

    // Gap timer only runs while a word is partially assembled and the line is idle
    assign w_gap_run = (r_k != '0) && w_line_idle;
    assign w_gap_hit = w_gap_run && (r_gap == c_gap_last);

    // Gap counter: expiry takes priority over a coincident start edge
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_gap <= '0;
        end else if (!w_gap_run || w_gap_hit || w_start_seen) begin
            r_gap <= '0;
        end else begin
            r_gap <= r_gap + c_gap_inc;
        end
    end

    // Word assembly, frame counter and status pulses
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_k     <= '0;
            r_word  <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_ferr  <= 1'b0;
            r_tmo   <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            r_ferr  <= 1'b0;
            r_tmo   <= 1'b0;
            if (w_frame_done) begin
                if (r_k == c_k_last) begin
                    r_data  <= w_word_next;
                    r_valid <= 1'b1;
                    r_busy  <= 1'b0;
                    r_k     <= '0;
                end else begin
                    r_word <= w_word_next;
                    r_k    <= r_k + c_k_inc;
                end
            end else if (w_frame_err) begin
                r_ferr <= 1'b1;
                r_busy <= 1'b0;
                r_k    <= '0;
            end else if (w_gap_hit) begin
                r_tmo  <= 1'b1;
                r_busy <= 1'b0;
                r_k    <= '0;
            end else if (w_start_ok) begin
                r_busy <= 1'b1;
            end
        end
    end

    assign bus.data_out      = r_data;
    assign bus.valid_out     = r_valid;
    assign bus.busy_out      = r_busy;
    assign bus.frame_err_out = r_ferr;
    assign bus.timeout_out   = r_tmo;

endmodule
`default_nettype wire

// File: tb/tb_recv_word.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module : tb_recv_word
// Brief  : Self-checking bench for recv_word; drives UART frames onto the
//          line and compares received words against a queue-based model.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
module tb_recv_word;

    localparam int C  = 25;
    localparam int F  = 8;
    localparam int N  = 2;
    localparam int G  = 16;
    localparam int DS = F * N;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_err    = 0;

    always #5 clk = ~clk;

    recv_word_if #(.DATA_SIZE(DS)) bus ();

    recv_word #(
        .CLK_BAUD_RATIO (C),
        .FRAME_SIZE     (F),
        .FRAMES         (N),
        .GAP_TIMEOUT    (G)
    ) dut (
        .clk_in   (clk),
        .rst_n_in (rst_n),
        .bus      (bus)
    );

    // Observer: counts pulses and records every delivered word
    int cyc    = 0;
    int n_valid = 0;
    int n_ferr = 0;
    int n_tmo  = 0;
    int n_excl = 0;
    int n_busy = 0;
    int t_tmo  = 0;
    logic [DS-1:0] got_q [$];

    always @(negedge clk) begin
        cyc++;
        if (bus.valid_out === 1'b1) begin
            n_valid++;
            got_q.push_back(bus.data_out);
        end
        if (bus.frame_err_out === 1'b1) n_ferr++;
        if (bus.timeout_out === 1'b1) begin
            n_tmo++;
            t_tmo = cyc;
        end
        if (bus.busy_out === 1'b1) n_busy++;
        if ((int'(bus.valid_out) + int'(bus.frame_err_out) + int'(bus.timeout_out)) > 1) n_excl++;
    end

    // Reference model: first frame occupies the low bits of the word
    function automatic logic [DS-1:0] pack(input logic [F-1:0] f0, input logic [F-1:0] f1);
        return DS'(f0) + (DS'(f1) << F);
    endfunction

    function automatic logic [DS-1:0] got_at(input int i);
        if (i < int'(got_q.size())) return got_q[i];
        return 'x;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle_bits(input int nbits);
        bus.rx_in = 1'b1;
        repeat (nbits * C) @(negedge clk);
    endtask

    task automatic send_frame(input logic [F-1:0] d, input logic stop);
        bus.rx_in = 1'b0;
        repeat (C) @(negedge clk);
        for (int i = 0; i < F; i++) begin
            bus.rx_in = d[i];
            repeat (C) @(negedge clk);
        end
        bus.rx_in = stop;
        repeat (C) @(negedge clk);
    endtask

    logic [DS-1:0] last_word;
    logic [DS-1:0] exp_q [$];
    logic [F-1:0]  fa;
    logic [F-1:0]  fb;
    int v0, f0, t0, b0, q0, t_end, d;

    initial begin
        bus.rx_in = 1'b1;
        last_word = '0;

        // Reset state
        repeat (4) @(negedge clk);
        check("rst_valid", 32'(bus.valid_out), 32'd0);
        check("rst_busy",  32'(bus.busy_out), 32'd0);
        check("rst_ferr",  32'(bus.frame_err_out), 32'd0);
        check("rst_tmo",   32'(bus.timeout_out), 32'd0);
        check("rst_data",  32'(bus.data_out), 32'd0);
        rst_n = 1'b1;
        idle_bits(2);

        // Back-to-back frames form one word
        v0 = n_valid; q0 = got_q.size();
        send_frame(8'h3C, 1'b1);
        check("t1_busy_mid", 32'(bus.busy_out), 32'd1);
        send_frame(8'hA5, 1'b1);
        idle_bits(3);
        last_word = pack(8'h3C, 8'hA5);
        check("t1_valid_cnt", 32'(n_valid - v0), 32'd1);
        check("t1_word", 32'(got_at(q0)), 32'(last_word));
        check("t1_data_out", 32'(bus.data_out), 32'(last_word));
        check("t1_busy_end", 32'(bus.busy_out), 32'd0);

        // Short low glitch is ignored
        v0 = n_valid; f0 = n_ferr; t0 = n_tmo; b0 = n_busy;
        bus.rx_in = 1'b0;
        repeat (5) @(negedge clk);
        idle_bits(3);
        check("t2_glitch_busy", 32'(n_busy - b0), 32'd0);
        check("t2_glitch_pulses", 32'((n_valid - v0) + (n_ferr - f0) + (n_tmo - t0)), 32'd0);
        q0 = got_q.size();
        send_frame(8'h55, 1'b1);
        send_frame(8'hAA, 1'b1);
        idle_bits(2);
        last_word = pack(8'h55, 8'hAA);
        check("t2_word", 32'(got_at(q0)), 32'(last_word));

        // Framing error on the first frame
        v0 = n_valid; f0 = n_ferr;
        send_frame(8'h12, 1'b0);
        idle_bits(2);
        check("t3_ferr_cnt", 32'(n_ferr - f0), 32'd1);
        check("t3_no_valid", 32'(n_valid - v0), 32'd0);
        check("t3_data_kept", 32'(bus.data_out), 32'(last_word));
        check("t3_busy", 32'(bus.busy_out), 32'd0);

        // Gap timeout after a single frame
        v0 = n_valid; t0 = n_tmo;
        send_frame(8'h12, 1'b1);
        t_end = cyc;
        idle_bits(17);
        d = t_tmo - t_end;
        check("t4_tmo_cnt", 32'(n_tmo - t0), 32'd1);
        check("t4_tmo_time", 32'((d >= 386) && (d <= 396)), 32'd1);
        check("t4_no_valid", 32'(n_valid - v0), 32'd0);
        check("t4_busy", 32'(bus.busy_out), 32'd0);
        q0 = got_q.size();
        send_frame(8'h34, 1'b1);
        send_frame(8'h56, 1'b1);
        idle_bits(2);
        last_word = pack(8'h34, 8'h56);
        check("t4_fresh_word", 32'(got_at(q0)), 32'(last_word));

        // Reset in the middle of the second frame's data bits
        send_frame(8'h77, 1'b1);
        bus.rx_in = 1'b0;
        repeat (C) @(negedge clk);
        bus.rx_in = 1'b1; repeat (C) @(negedge clk);
        bus.rx_in = 1'b0; repeat (C) @(negedge clk);
        v0 = n_valid; f0 = n_ferr; t0 = n_tmo;
        rst_n = 1'b0;
        #1;
        check("t5_rst_data", 32'(bus.data_out), 32'd0);
        check("t5_rst_busy", 32'(bus.busy_out), 32'd0);
        check("t5_rst_valid", 32'(bus.valid_out), 32'd0);
        bus.rx_in = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        idle_bits(20);
        check("t5_no_pulses", 32'((n_valid - v0) + (n_ferr - f0) + (n_tmo - t0)), 32'd0);
        q0 = got_q.size();
        send_frame(8'h9A, 1'b1);
        send_frame(8'hBC, 1'b1);
        idle_bits(2);
        check("t5_word", 32'(got_at(q0)), 32'(pack(8'h9A, 8'hBC)));

        // Random transmitter stream
        q0 = got_q.size();
        for (int w = 0; w < 100; w++) begin
            fa = F'($urandom);
            fb = F'($urandom);
            exp_q.push_back(pack(fa, fb));
            send_frame(fa, 1'b1);
            idle_bits(int'($urandom_range(0, 2)));
            send_frame(fb, 1'b1);
            idle_bits(int'($urandom_range(0, 3)));
        end
        idle_bits(2);
        check("rnd_count", 32'(int'(got_q.size()) - q0), 32'd100);
        for (int i = 0; i < 100; i++) begin
            check($sformatf("rnd_word%0d", i), 32'(got_at(q0 + i)), 32'(exp_q[i]));
        end
        check("excl_pulses", 32'(n_excl), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
`default_nettype wire
